// File: rtl/sweep_ctrl.sv
// Triangle-sweep sequencer with an internal up/down counter: counts lo..hi..lo
// for a latched number of sweeps and reports busy/done/err as registered pulses.
module sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [WIDTH-1:0]   i_lo,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [SWEEP_W-1:0] i_sweeps,
  output logic [WIDTH-1:0]   o_cnt,
  output logic               o_mode,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [1:0]         o_state
);

  // Handshake: i_start is a level request honoured only in IDLE (o_busy low);
  // i_abort is honoured only while o_busy is high. Neither is acknowledged
  // beyond o_busy rising (accepted), o_err pulsing (rejected) or o_busy falling.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d, cnt_d;
  logic [SWEEP_W-1:0] left_q, left_d;
  logic               mode_d, busy_d, done_d, err_d;

  assign o_state = state_q;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    left_d  = left_q;
    cnt_d   = o_cnt;
    mode_d  = o_mode;
    busy_d  = o_busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_lo >= i_hi || i_sweeps == '0) begin
            err_d = 1'b1;
          end else begin
            lo_d    = i_lo;
            hi_d    = i_hi;
            left_d  = i_sweeps;
            cnt_d   = i_lo;
            mode_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = UP;
          end
        end
      end
      UP: begin
        if (i_abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (o_cnt != hi_q) begin
          cnt_d = o_cnt + 1'b1;
        end else begin
          cnt_d   = hi_q - 1'b1;
          mode_d  = 1'b1;
          state_d = DOWN;
        end
      end
      DOWN: begin
        if (i_abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (o_cnt != lo_q) begin
          cnt_d = o_cnt - 1'b1;
        end else if (left_q > SWEEP_W'(1)) begin
          // The turnaround lo is shared with the next sweep, so it appears once.
          left_d  = left_q - 1'b1;
          cnt_d   = lo_q + 1'b1;
          mode_d  = 1'b0;
          state_d = UP;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      left_q  <= '0;
      o_cnt   <= '0;
      o_mode  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      left_q  <= left_d;
      o_cnt   <= cnt_d;
      o_mode  <= mode_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
      o_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: a vector table for nominal, reject, abort and reset
// cases, plus generated triangle runs (full range and random windows).
module tb_sweep_ctrl;

  localparam int W = 10;
  localparam logic [1:0] S_I = 2'd0, S_U = 2'd1, S_D = 2'd2, S_N = 2'd3;

  typedef struct {
    string      name;
    logic       rst, start, abort;
    logic [3:0] lo, hi, sw;
    logic [3:0] cnt;
    logic       mode, busy, done, err;
    logic [1:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] lo = '0, hi = '0, sweeps = '0;
  logic [3:0] cnt;
  logic       mode, busy, done, err;
  logic [1:0] state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  vec_t         vt[$];
  int           checks = 0;
  int           errors = 0;

  sweep_ctrl #(.WIDTH(4), .SWEEP_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_lo(lo), .i_hi(hi), .i_sweeps(sweeps),
    .o_cnt(cnt), .o_mode(mode), .o_busy(busy), .o_done(done), .o_err(err),
    .o_state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(string n, logic r, logic s, logic a,
                              logic [3:0] l, logic [3:0] h, logic [3:0] w,
                              logic [3:0] c, logic m, logic b, logic d,
                              logic e, logic [1:0] st);
    vec_t v;
    v.name = n; v.rst = r; v.start = s; v.abort = a;
    v.lo = l; v.hi = h; v.sw = w;
    v.cnt = c; v.mode = m; v.busy = b; v.done = d; v.err = e; v.st = st;
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic apply(input vec_t v);
    logic [W-1:0] act, exp;
    string        nm;
    @(negedge clk);
    rst = v.rst; start = v.start; abort = v.abort;
    lo = v.lo; hi = v.hi; sweeps = v.sw;
    exp_q.push_back({v.cnt, v.mode, v.busy, v.done, v.err, v.st});
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    act = {cnt, mode, busy, done, err, state};
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d mode=%b busy=%b done=%b err=%b st=%0d, exp cnt=%0d mode=%b busy=%b done=%b err=%b st=%0d",
               nm, act[9:6], act[5], act[4], act[3], act[2], act[1:0],
               exp[9:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Accepted start followed by the full triangle, DONE pulse and return to IDLE.
  // Mid-sweep cycles carry random (ignored) start requests with random bounds.
  task automatic run_sweep(input string n, input int l, input int h, input int w);
    vec_t v;
    apply(mk(n, 0, 1, 0, 4'(l), 4'(h), 4'(w), 4'(l), 0, 1, 0, 0, S_U));
    for (int s = 0; s < w; s++) begin
      for (int x = l + 1; x <= h; x++) begin
        v = mk(n, 0, 1'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'(x), 0, 1, 0, 0, S_U);
        apply(v);
      end
      for (int x = h - 1; x >= l; x--) begin
        v = mk(n, 0, 1'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'(x), 1, 1, 0, 0, S_D);
        apply(v);
      end
    end
    apply(mk({n, "_done"}, 0, 1, 0, 4'(0), 4'(9), 4'(1), 4'(l), 1, 0, 1, 0, S_N));
    apply(mk({n, "_idle"}, 0, 0, 0, 0, 0, 0, 4'(l), 1, 0, 0, 0, S_I));
  endtask

  initial begin
    // reset
    vt.push_back(mk("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_I));
    vt.push_back(mk("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_I));
    // nominal lo=2 hi=5 sweeps=2, with ignored mid-sweep and DONE starts
    vt.push_back(mk("nom0",  0, 1, 0, 2, 5, 2, 2, 0, 1, 0, 0, S_U));
    vt.push_back(mk("nom1",  0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, S_U));
    vt.push_back(mk("nom2",  0, 1, 0, 0, 9, 7, 4, 0, 1, 0, 0, S_U));
    vt.push_back(mk("nom3",  0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, S_U));
    vt.push_back(mk("nom4",  0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, S_D));
    vt.push_back(mk("nom5",  0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, S_D));
    vt.push_back(mk("nom6",  0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, S_D));
    vt.push_back(mk("nom7",  0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, S_U));
    vt.push_back(mk("nom8",  0, 1, 0, 1, 2, 1, 4, 0, 1, 0, 0, S_U));
    vt.push_back(mk("nom9",  0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, S_U));
    vt.push_back(mk("nom10", 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, S_D));
    vt.push_back(mk("nom11", 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, S_D));
    vt.push_back(mk("nom12", 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, S_D));
    vt.push_back(mk("nom13", 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, S_N));
    vt.push_back(mk("nom14_start_in_done", 0, 1, 0, 1, 3, 1, 2, 1, 0, 0, 0, S_I));
    vt.push_back(mk("restart0", 0, 1, 0, 1, 3, 1, 1, 0, 1, 0, 0, S_U));
    vt.push_back(mk("restart1", 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, S_U));
    vt.push_back(mk("restart2", 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, S_U));
    vt.push_back(mk("restart3", 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, S_D));
    vt.push_back(mk("restart4", 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, S_D));
    vt.push_back(mk("restart5", 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, S_N));
    vt.push_back(mk("restart6", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, S_I));
    // rejected starts
    vt.push_back(mk("rej_eq",      0, 1, 0, 5, 5, 1, 1, 1, 0, 0, 1, S_I));
    vt.push_back(mk("rej_eq_clr",  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, S_I));
    vt.push_back(mk("rej_sw0",     0, 1, 0, 1, 4, 0, 1, 1, 0, 0, 1, S_I));
    vt.push_back(mk("rej_sw0_clr", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, S_I));
    vt.push_back(mk("rej_gt",      0, 1, 0, 9, 3, 2, 1, 1, 0, 0, 1, S_I));
    vt.push_back(mk("rej_gt_clr",  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, S_I));
    // start+abort in IDLE, then abort at the UP turnaround
    vt.push_back(mk("stab0",      0, 1, 1, 2, 5, 2, 2, 0, 1, 0, 0, S_U));
    vt.push_back(mk("stab1",      0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, S_U));
    vt.push_back(mk("stab2",      0, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0, S_U));
    vt.push_back(mk("stab3",      0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, S_U));
    vt.push_back(mk("abort_up",   0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, S_I));
    vt.push_back(mk("abort_idle", 0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, S_I));
    // start after abort, then abort beats completion at lo
    vt.push_back(mk("ab2_0",      0, 1, 0, 7, 9, 1, 7, 0, 1, 0, 0, S_U));
    vt.push_back(mk("ab2_1",      0, 0, 0, 0, 0, 0, 8, 0, 1, 0, 0, S_U));
    vt.push_back(mk("ab2_2",      0, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, S_U));
    vt.push_back(mk("ab2_3",      0, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, S_D));
    vt.push_back(mk("ab2_4",      0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, S_D));
    vt.push_back(mk("abort_dn",   0, 0, 1, 0, 0, 0, 7, 1, 0, 0, 0, S_I));
    vt.push_back(mk("abort_dn_i", 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, S_I));
    // reset mid-UP at cnt=3, and reset beating a start in IDLE
    vt.push_back(mk("mid0",     0, 1, 0, 1, 6, 1, 1, 0, 1, 0, 0, S_U));
    vt.push_back(mk("mid1",     0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, S_U));
    vt.push_back(mk("mid2",     0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, S_U));
    vt.push_back(mk("rst_mid",  1, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, S_I));
    vt.push_back(mk("rst_strt", 1, 1, 0, 2, 5, 1, 0, 0, 0, 0, 0, S_I));
    vt.push_back(mk("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_I));

    for (int i = 0; i < vt.size(); i++) apply(vt[i]);

    run_sweep("full", 0, 15, 1);
    for (int r = 0; r < 3; r++) begin
      int l, h, w;
      l = $urandom_range(0, 14);
      h = $urandom_range(l + 1, 15);
      w = $urandom_range(1, 3);
      run_sweep($sformatf("rand%0d", r), l, h, w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Sequencer for a 4-bit up/down binary counter datapath: on a start request it latches a window [lo, hi] and a sweep count, then drives the count up from lo to hi and back down to lo, repeating for the requested number of sweeps, with the up/down direction exported as a mode bit. It sits between a host/test controller and the counter display/consumer path, replacing free-running up/down counting with a bounded, handshaked triangle sweep. The counter register is internal, so the block is the complete sequenced datapath.

## Interface
- WIDTH, 4: count and window-bound width.
- SWEEP_W, 4: sweep-count width.

- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request, sampled in IDLE only.
- i_abort  in  1  abort request, sampled while busy only.
- i_lo  in  WIDTH  lower window bound, latched on accepted start.
- i_hi  in  WIDTH  upper window bound, latched on accepted start.
- i_sweeps  in  SWEEP_W  number of full up+down sweeps, latched on accepted start.
- o_cnt  out  WIDTH  current count (registered).
- o_mode  out  1  direction: 0 = up, 1 = down (registered).
- o_busy  out  1  high in UP/DOWN states.
- o_done  out  1  one-cycle pulse on normal completion.
- o_err  out  1  one-cycle pulse on rejected start.

## Operation
- States: IDLE, UP, DOWN, DONE. All outputs are registered.
- Reset (i_rst=1 at an edge): state IDLE, o_cnt=0, o_mode=0, o_busy=0, o_done=0, o_err=0, internal sweeps-left=0. Reset overrides all other inputs, including mid-sweep.
- IDLE, i_start=1:
  - If i_lo >= i_hi or i_sweeps == 0: o_err=1 for one cycle, stay IDLE, o_cnt/o_mode unchanged.
  - Otherwise: latch bounds, sweeps-left=i_sweeps, o_cnt=i_lo, o_mode=0, o_busy=1, go to UP.
- i_abort is ignored in IDLE, including when i_start is high in the same cycle; start is processed.
- UP: if o_cnt != hi, increment o_cnt. If o_cnt == hi, go to DOWN, o_mode=1, o_cnt=hi-1.
- DOWN: if o_cnt != lo, decrement o_cnt.
  - If o_cnt == lo and sweeps-left > 1: decrement sweeps-left, go to UP, o_mode=0, o_cnt=lo+1.
  - If o_cnt == lo and sweeps-left == 1: go to DONE, o_busy=0, o_done=1, o_cnt holds lo.
- DONE: lasts exactly one cycle, then IDLE with o_done=0. i_start in DONE is ignored.
- i_abort=1 in UP/DOWN: next edge goes to IDLE, o_busy=0, o_cnt and o_mode hold, no o_done. Abort has priority over the turnaround and completion transitions in the same cycle.
- i_start while busy is ignored. Latched bounds are unaffected by input changes mid-sweep.
- Arithmetic: unsigned. Because lo < hi is enforced, o_cnt never wraps. hi = 2^WIDTH-1 and lo = 0 are legal.

## Timing
- Start latency: o_cnt=lo and o_busy=1 are visible after the edge that samples i_start.
- Per sweep, the sequence is lo, lo+1, …, hi, hi-1, …, lo. hi appears for one cycle. An intermediate lo appears for one cycle, shared between adjacent sweeps.
- o_busy high duration: 1 + 2·(hi−lo)·sweeps cycles. o_done is asserted in the cycle immediately after o_busy falls.
- o_err rises one cycle after a rejected start and lasts one cycle.
- o_mode changes on the same edge as the first step in the new direction.

## Test plan
- Reset: assert i_rst mid-UP with o_cnt=3 -> after one edge, o_cnt=0, o_mode=0, o_busy=0, o_done=0, o_err=0, state IDLE.
- Nominal: lo=2, hi=5, sweeps=2, start at edge 0.
  - Required o_cnt after edges 0..13: 2,3,4,5,4,3,2,3,4,5,4,3,2,2.
  - o_mode is 1 after edges 4–6 and 10–13; after edge 7 it is 0.
  - o_busy=1 after edges 0–12. o_done=1 only after edge 13, o_busy=0 then. State is IDLE after edge 14.
- Rejected start: lo=5, hi=5, or lo=1, hi=4, sweeps=0 -> o_err pulses one cycle, o_busy stays 0, o_cnt unchanged.
- Full range: lo=0, hi=15, sweeps=1 -> o_cnt goes 0..15..0, no wrap. o_busy high for 31 cycles, then o_done.
- Abort: lo=2, hi=5, sweeps=2, i_abort at the cycle where o_cnt=5 (UP turnaround) -> o_cnt holds 5, o_mode holds 0, o_busy=0, no o_done. A following start is accepted.
- Ignored inputs:
  - i_start pulsed mid-sweep with different bounds -> sequence unchanged.
  - i_start during DONE -> ignored; a start one cycle later is accepted.
  - i_start+i_abort together in IDLE -> start accepted.
